// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit cores.
//   - rx_state_e : receiver FSM state encoding
//   - DEF_*      : default frame geometry
//   - clog2      : counter width helper, never returns less than 1
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus falling-edge detect.
//   rx_clk  : receive clock
//   reset_n : async active-low reset; all flops reset to 1 (line idle)
//   rx      : raw serial line
//   rx_s    : synchronized line (second flop)
//   fall    : high for the one cycle in which rx_s goes from 1 to 0
module uart_rx_sync (
    input  logic rx_clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic s1_q, s2_q, prev_q;
    logic s1_d, s2_d, prev_d;

    always_comb begin
        s1_d   = rx;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s = s2_q;
    assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: frames start/data/optional parity/stop (LSB first),
// holds one word behind a valid/ready handshake and reports errors.
//   rx_clk, reset_n       : clock, async active-low reset
//   rx                    : asynchronous serial line (idle high)
//   rx_data, rx_valid     : holding register and its full flag
//   rx_ready              : consumer accept
//   rx_done               : one-cycle pulse per completed frame
//   frame_err, parity_err : error flags travelling with rx_data
//   overrun               : one-cycle pulse when a frame is dropped
//   busy                  : FSM not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_IDLE   | waiting for a falling edge on the synchronized line
// RX_START  | waiting half a bit to confirm the start bit (glitch filter)
// RX_DATA   | sampling DATA_BITS data bits, one per bit period
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling the stop bit, then deliver or flag overrun
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 rx_clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int BIT_W = clog2(DATA_BITS);
    // The start-bit check lands mid-bit; every later sample is one full
    // period after the previous one, so all samples stay mid-bit.
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    logic rx_s, fall;

    uart_rx_sync u_sync (
        .rx_clk  (rx_clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_pend_q, par_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 accept;
    logic                 par_calc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_pend_d = par_pend_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;
        accept     = valid_q & rx_ready;
        par_calc   = (^shreg_q) ^ rx_s;

        if (accept) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
        end

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d    = RX_START;
                    bit_d      = '0;
                    par_pend_d = 1'b0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    par_pend_d = (par_calc != ODD);
                    state_d    = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    done_d  = 1'b1;
                    // A word being drained this very edge frees the slot.
                    if (!valid_q || accept) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        ferr_d  = ~rx_s;
                        perr_d  = par_pend_q;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            par_pend_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            par_pend_q <= par_pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign rx_done    = done_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    logic       clk;
    logic       reset_n;
    logic       rx0, rx1;
    logic       rdy0, rdy1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, done0, done1;
    logic       ferr0, ferr1, perr0, perr1;
    logic       ovr0, ovr1, busy0, busy1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t_start;
    int done_cnt0 = 0, done_cnt1 = 0, ovr_cnt0 = 0, ovr_cnt1 = 0;
    int last_done0 = 0;
    int base;

    // expected word: {data, frame_err, parity_err}
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    uart_rx_core dut0 (
        .rx_clk(clk), .reset_n(reset_n), .rx(rx0),
        .rx_data(data0), .rx_valid(valid0), .rx_ready(rdy0),
        .rx_done(done0), .frame_err(ferr0), .parity_err(perr0),
        .overrun(ovr0), .busy(busy0)
    );

    uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .rx_clk(clk), .reset_n(reset_n), .rx(rx1),
        .rx_data(data1), .rx_valid(valid1), .rx_ready(rdy1),
        .rx_done(done1), .frame_err(ferr1), .parity_err(perr1),
        .overrun(ovr1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop and compare whenever a word is accepted.
    always @(negedge clk) begin : mon0
        logic [9:0] e;
        if (reset_n) begin
            if (done0) begin done_cnt0++; last_done0 = cyc; end
            if (ovr0) ovr_cnt0++;
            if (valid0 && rdy0) begin
                if (q0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut0_unexpected_word: got %0h expected none", data0);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_word", {22'd0, data0, ferr0, perr0}, {22'd0, e});
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [9:0] e;
        if (reset_n) begin
            if (done1) done_cnt1++;
            if (ovr1) ovr_cnt1++;
            if (valid1 && rdy1) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut1_unexpected_word: got %0h expected none", data1);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_word", {22'd0, data1, ferr1, perr1}, {22'd0, e});
                end
            end
        end
    end

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit pe,
                              input logic pbit, input logic stop);
        @(negedge clk);
        drive(which, 1'b0);
        t_start = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            repeat (16) @(negedge clk);
        end
        if (pe) begin
            drive(which, pbit);
            repeat (16) @(negedge clk);
        end
        drive(which, stop);
        repeat (16) @(negedge clk);
    endtask

    task automatic pulse_ready0();
        @(posedge clk); #1 rdy0 = 1'b1;
        @(posedge clk); #1 rdy0 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // reset state
        chk("rst_data",   {24'd0, data0}, 32'h0);
        chk("rst_valid",  {31'd0, valid0}, 32'h0);
        chk("rst_done",   {31'd0, done0}, 32'h0);
        chk("rst_ferr",   {31'd0, ferr0}, 32'h0);
        chk("rst_perr",   {31'd0, perr0}, 32'h0);
        chk("rst_ovr",    {31'd0, ovr0}, 32'h0);
        chk("rst_busy",   {31'd0, busy0}, 32'h0);

        // 0xA5, 8N1, held until rx_ready
        base = done_cnt0;
        q0.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("a5_done_latency", last_done0 - t_start, 155);
        chk("a5_done_count", done_cnt0 - base, 1);
        chk("a5_valid", {31'd0, valid0}, 32'h1);
        chk("a5_data", {24'd0, data0}, 32'hA5);
        repeat (50) @(negedge clk);
        chk("a5_valid_held", {31'd0, valid0}, 32'h1);
        pulse_ready0();
        @(negedge clk);
        chk("a5_valid_cleared", {31'd0, valid0}, 32'h0);

        // glitch: 3 cycles low
        base = done_cnt0;
        @(negedge clk);
        rx0 = 1'b0;
        repeat (3) @(negedge clk);
        rx0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_start", {31'd0, busy0}, 32'h1);
        repeat (15) @(negedge clk);
        chk("glitch_busy_idle", {31'd0, busy0}, 32'h0);
        repeat (200) @(negedge clk);
        chk("glitch_no_done", done_cnt0 - base, 0);
        chk("glitch_no_valid", {31'd0, valid0}, 32'h0);

        // framing error, then line held low
        rdy0 = 1'b1;
        base = done_cnt0;
        q0.push_back({8'h3C, 1'b1, 1'b0});
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40 * 16) @(negedge clk);
        rx0 = 1'b1;
        repeat (40) @(negedge clk);
        chk("ferr_one_frame", done_cnt0 - base, 1);
        chk("ferr_q_empty", q0.size(), 0);

        // overrun: two back-to-back frames with no drain
        rdy0 = 1'b0;
        base = done_cnt0;
        q0.push_back({8'h11, 1'b0, 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("ovr_done_count", done_cnt0 - base, 2);
        chk("ovr_pulses", ovr_cnt0, 1);
        chk("ovr_data_kept", {24'd0, data0}, 32'h11);
        chk("ovr_valid", {31'd0, valid0}, 32'h1);
        pulse_ready0();
        @(negedge clk);
        chk("ovr_valid_cleared", {31'd0, valid0}, 32'h0);

        // parity, even: 0x01 + 1 good, 0x01 + 0 bad, 0x03 + 0 good
        q1.push_back({8'h01, 1'b0, 1'b0});
        send_frame(1, 8'h01, 1'b1, 1'b1, 1'b1);
        q1.push_back({8'h01, 1'b0, 1'b1});
        send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1);
        q1.push_back({8'h03, 1'b0, 1'b0});
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("par_done_count", done_cnt1, 3);
        chk("par_q_empty", q1.size(), 0);

        // reset mid-frame with a word already held
        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", {31'd0, valid0}, 32'h1);
        @(negedge clk);
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx0 = (8'h5A >> i) & 1'b1;
            repeat (16) @(negedge clk);
        end
        rx0 = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_busy", {31'd0, busy0}, 32'h1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_data",  {24'd0, data0}, 32'h0);
        chk("mrst_valid", {31'd0, valid0}, 32'h0);
        chk("mrst_busy",  {31'd0, busy0}, 32'h0);
        chk("mrst_flags", {29'd0, ferr0, perr0, done0}, 32'h0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        rdy0 = 1'b1;
        base = done_cnt0;
        q0.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("post_rst_done", done_cnt0 - base, 1);
        chk("final_q0_empty", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receiver core of the Avalon UART slave; the receive-side counterpart of tx_core.
- Samples the asynchronous rx line with a 2-flop synchronizer.
- Frames start / data / optional parity / stop bits, LSB first.
- Presents each received word on a valid/ready handshake to the Avalon register block.
- One-word holding register; overrun, framing and parity error flags.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
CLKS_PER_BIT, 16, rx_clk cycles per bit period (even, >=4)
PARITY_EN, 0, 1 = parity bit expected after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)

Ports:
rx_clk  input  1  receive clock; all state on rising edge
reset_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to rx_clk
rx_data  output  DATA_BITS  received word, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts word when rx_valid&rx_ready
rx_done  output  1  one-cycle pulse per completed frame (good or bad)
frame_err  output  1  stop bit sampled 0; qualifies rx_data with rx_valid
parity_err  output  1  parity mismatch; qualifies rx_data with rx_valid
overrun  output  1  one-cycle pulse: frame completed while holding register full and not drained
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE, counters 0, synchronizer flops to 1.
  - Outputs: rx_data=0, rx_valid=0, rx_done=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - Reset mid-frame aborts the frame; no partial word is delivered.
- Synchronizer: rx -> s1 -> s2; prev = s2 delayed one cycle.
  - Falling edge = prev=1 & s2=0.
  - "Detect cycle" D = the cycle the edge is seen, 2-3 cycles after the pin transition.
- Baud counter: counts 0..CLKS_PER_BIT-1; bit counter counts 0..DATA_BITS-1.
- IDLE: on falling edge go to START, baud counter cleared. A line held low never retriggers; an edge is required.
- START: sample s2 at D+CLKS_PER_BIT/2.
  - s2=1: glitch, return to IDLE, no flags.
  - s2=0: go to DATA, counter cleared.
- DATA: sample every CLKS_PER_BIT cycles; shift right into the shift register (first bit lands in bit 0). After DATA_BITS samples go to PARITY if PARITY_EN, else STOP.
- PARITY: one sample.
  - Error if XOR(data bits, parity bit) != PARITY_ODD.
- STOP: sample at mid-bit, then go straight to IDLE in the same cycle. This allows back-to-back frames whose next start edge follows immediately.
- Completion: the stop sample occurs at D + CLKS_PER_BIT/2 + (1+DATA_BITS+PARITY_EN)*CLKS_PER_BIT. In the next cycle (C):
  - rx_done=1 for exactly one cycle.
  - If rx_valid=0, or rx_valid&rx_ready in the cycle of the stop sample: load rx_data and the flags, set rx_valid=1.
  - Else: old word and flags kept, overrun=1 for one cycle, new frame discarded.
- Handshake: rx_valid&rx_ready clears rx_valid next cycle unless a new word loads that same edge.
  - frame_err and parity_err are held with their word.
  - frame_err and parity_err are cleared to 0 on the accepting edge when no new word loads.
- Frame error still delivers the word (data bits as sampled); the receiver re-arms only on the next falling edge.
- Line noise mid-frame is not re-checked; single-sample decision per bit.

Decomposition:
- uart_pkg (shared with tx_core):
  - state encoding constants RX_IDLE/RX_START/RX_DATA/RX_PARITY/RX_STOP
  - default CLKS_PER_BIT and DATA_BITS
  - clog2 function for counter widths
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detector.
  - Ports: rx_clk, reset_n, rx, rx_s, fall.
  - Reset value 1.

Test Plan:
- Defaults; send 0xA5 (8N1, exact bit timing), rx_ready=0 -> rx_valid=1 and rx_done pulse at D+153, rx_data=0xA5, frame_err=0, parity_err=0, held until rx_ready.
- Drive rx low for 3 cycles only (glitch) -> return to IDLE at D+8; no rx_done, busy drops, nothing delivered.
- Send 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1. Hold rx low 40 more bit times -> no second frame.
- PARITY_EN=1, PARITY_ODD=0: send 0x01 with parity 1 -> parity_err=0. Resend with parity 0 -> parity_err=1, rx_valid=1.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> first word kept, overrun pulses once at second completion, rx_data stays 0x11.
- Assert reset_n=0 during DATA bit 4 of a frame, then release -> all outputs 0, busy=0; the next full frame 0x5A is received correctly.
